mdu_iter: RTL and testbench
===========================

MDU_ITER -- requirements
Module: mdu_iter

Interface
REQ-001 Parameter DATA_WIDTH, 32, operand and result width; SHALL be even and >= 8.
REQ-002 Parameter OP_WIDTH, 3, operation select width; SHALL carry RV32M funct3 encoding.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-low; asserts immediately, deasserts synchronously to clk.
REQ-005 start  input  1  request strobe; SHALL be sampled only in IDLE.
REQ-006 op  input  OP_WIDTH  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-007 op_a  input  DATA_WIDTH  rs1 operand (multiplicand / dividend).
REQ-008 op_b  input  DATA_WIDTH  rs2 operand (multiplier / divisor).
REQ-009 flush  input  1  synchronous abort of the operation in flight.
REQ-010 busy  output  1  high from the cycle after start is accepted until done.
REQ-011 done  output  1  one-cycle pulse; result valid in that cycle.
REQ-012 result  output  DATA_WIDTH  registered result, held until the next accepted start.

Function
REQ-013 op, op_a and op_b SHALL be captured internally on the accepting edge; later changes SHALL not affect the result.
REQ-014 The FSM SHALL have states IDLE, CALC, FIX and DONE.
REQ-015 IDLE->CALC on start=1, except for the fast paths in REQ-021 and REQ-022.
REQ-016 CALC SHALL iterate exactly DATA_WIDTH cycles, 1 bit per cycle, then go to FIX.
REQ-017 FIX SHALL apply sign correction and select the high or low half, then go to DONE.
REQ-018 DONE SHALL pulse done for 1 cycle, return to IDLE, and drop busy in the same cycle.
REQ-019 Latency SHALL be DATA_WIDTH+2 cycles from the accepting edge to done=1 (34 for DATA_WIDTH=32); back-to-back start is allowed in the cycle after done.
REQ-020 Multiply SHALL be shift-add on magnitudes with a 2*DATA_WIDTH accumulator.
  - MUL: low half.
  - MULH: high half, signed x signed.
  - MULHSU: high half, signed x unsigned.
  - MULHU: high half, unsigned x unsigned.
  - Negation SHALL be two's complement of the full 2*DATA_WIDTH product.
REQ-021 Divide SHALL use restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b); remainder sign = sign(a), for DIV and REM.
  - Divisor 0: quotient all ones, remainder = op_a.
  - This case SHALL skip CALC and FIX: IDLE->DONE, done at cycle 2.
REQ-022 Signed overflow (op_a = most-negative, op_b = all ones, DIV/REM) SHALL return quotient = op_a and remainder = 0 via the same 2-cycle fast path.
REQ-023 start while busy=1 SHALL be ignored with no effect on state.
REQ-024 flush=1 in any non-IDLE state SHALL force IDLE next cycle.
  - Abort SHALL be silent: no done pulse, result unchanged.
  - flush in IDLE together with start SHALL suppress acceptance.
REQ-025 flush and DONE in the same cycle: done SHALL still pulse, since the result is already committed.

Reset
REQ-026 While rst=0: state=IDLE, busy=0, done=0, result=0, all internal accumulators and counters=0.
REQ-027 Reset asserted mid-operation SHALL abandon the operation; no done SHALL follow deassertion.
REQ-028 The first start SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-029 MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB, done high exactly at cycle 34, busy high cycles 1-33.
REQ-030 MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
REQ-032 DIVU 0x1234 / 0 -> 0xFFFFFFFF and REM 0x1234 / 0 -> 0x1234, both with done at cycle 2; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, REM -> 0, done at cycle 2.
REQ-033 Start MUL, pulse start with new operands at cycle 5 -> ignored and original result returned; flush at cycle 10 -> IDLE at cycle 11, no done, result holds its prior value.
REQ-034 rst=0 at cycle 12 of a DIV -> busy, done and result go 0 asynchronously; no done afterwards; a new MUL 3 x 5 issued after reset -> 15 at cycle 34.

Source files
------------

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit.
// Multiplies by shift-add and divides by restoring division, both on operand
// magnitudes, one bit per cycle; a final FIX cycle applies the sign and picks
// the result half. Divide-by-zero and signed overflow return in two cycles.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   start   request strobe, sampled only while idle
//   op      funct3 select: MUL MULH MULHSU MULHU DIV DIVU REM REMU
//   op_a    rs1 operand (multiplicand / dividend)
//   op_b    rs2 operand (multiplier / divisor)
//   flush   synchronous abort of the operation in flight
//   busy    high while an accepted operation is in progress
//   done    one-cycle pulse, result valid in that cycle
//   result  registered result, held until replaced
module mdu_iter #(
  parameter int unsigned DATA_WIDTH = 32,  // even, >= 8
  parameter int unsigned OP_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_WIDTH-1:0]   op,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  input  logic                  flush,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);

  localparam int unsigned W     = DATA_WIDTH;
  localparam int unsigned W2    = 2 * DATA_WIDTH;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_WIDTH - 1);
  localparam logic [W-1:0] ZERO    = '0;
  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W2-1:0]    acc_q, acc_d;       // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     addend_q, addend_d; // multiplicand or divisor magnitude
  logic [2:0]       op_q, op_d;
  logic             neg_q, neg_d;       // final result must be negated
  logic             hold_q, hold_d;     // fast path: one wait cycle before done
  logic             busy_d, done_d;
  logic [W-1:0]     result_d;

  // Operand decode on the request inputs
  logic         in_div, sgn_a_en, sgn_b_en, sa, sb, neg_in;
  logic         div_zero, div_ovf, fast;
  logic [W-1:0] a_mag, b_mag, fast_val;

  always_comb begin
    in_div   = op[2];
    sgn_a_en = in_div ? ~op[0] : (op[1] ^ op[0]);
    sgn_b_en = in_div ? ~op[0] : (op[1:0] == 2'b01);
    sa       = op_a[W-1] & sgn_a_en;
    sb       = op_b[W-1] & sgn_b_en;
    a_mag    = sa ? -op_a : op_a;
    b_mag    = sb ? -op_b : op_b;
    // Remainder follows the dividend sign; products and quotients use the XOR.
    neg_in   = (in_div && op[1]) ? sa : (sa ^ sb);
    div_zero = in_div && (op_b == ZERO);
    div_ovf  = in_div && !op[0] && (op_a == MIN_NEG) && (op_b == '1);
    fast     = div_zero || div_ovf;
    if (div_zero) fast_val = op[1] ? op_a : '1;
    else          fast_val = op[1] ? ZERO : op_a;
  end

  // One iteration step for each datapath
  logic [W:0]   mul_sum, div_shift, div_diff;
  logic [W2-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, addend_q} : {(W+1){1'b0}});
    mul_next  = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[W2-1:W], acc_q[W-1]};
    div_diff  = div_shift - {1'b0, addend_q};
    if (div_diff[W]) div_next = {div_shift[W-1:0], acc_q[W-2:0], 1'b0};
    else             div_next = {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};
  end

  // Sign correction and half selection
  logic [W2-1:0] prod_fix;
  logic [W-1:0]  quo_fix, rem_fix, fix_val;

  always_comb begin
    prod_fix = neg_q ? -acc_q : acc_q;
    quo_fix  = neg_q ? -acc_q[W-1:0]  : acc_q[W-1:0];
    rem_fix  = neg_q ? -acc_q[W2-1:W] : acc_q[W2-1:W];
    if (op_q[2])               fix_val = op_q[1] ? rem_fix : quo_fix;
    else if (op_q[1:0] == 2'b00) fix_val = prod_fix[W-1:0];
    else                       fix_val = prod_fix[W2-1:W];
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    addend_d = addend_q;
    op_d     = op_q;
    neg_d    = neg_q;
    hold_d   = hold_q;
    busy_d   = busy;
    done_d   = 1'b0;
    result_d = result;

    case (state_q)
      IDLE: begin
        if (start && !flush) begin
          op_d   = op[2:0];
          neg_d  = neg_in;
          cnt_d  = '0;
          busy_d = 1'b1;
          if (fast) begin
            state_d = DONE;
            hold_d  = 1'b1;
            acc_d   = {ZERO, fast_val};
          end else begin
            state_d  = CALC;
            acc_d    = in_div ? {ZERO, a_mag} : {ZERO, b_mag};
            addend_d = in_div ? b_mag : a_mag;
          end
        end
      end

      CALC: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          acc_d = op_q[2] ? div_next : mul_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_CNT) state_d = FIX;
        end
      end

      FIX: begin
        busy_d = 1'b0;
        if (flush) begin
          state_d = IDLE;
        end else begin
          state_d  = DONE;
          done_d   = 1'b1;
          result_d = fix_val;
        end
      end

      DONE: begin
        // A committed result (hold clear) is already on done; flush cannot revoke it.
        if (hold_q) begin
          hold_d = 1'b0;
          busy_d = 1'b0;
          if (flush) begin
            state_d = IDLE;
          end else begin
            done_d   = 1'b1;
            result_d = acc_q[W-1:0];
          end
        end else begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      addend_q <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      hold_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      result   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      addend_q <= addend_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      hold_q   <= hold_d;
      busy     <= busy_d;
      done     <= done_d;
      result   <= result_d;
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: directed corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_mdu_iter;

  localparam int unsigned DW = 32;

  logic          clk   = 1'b0;
  logic          rst   = 1'b0;
  logic          start = 1'b0;
  logic          flush = 1'b0;
  logic [2:0]    op    = '0;
  logic [DW-1:0] op_a  = '0;
  logic [DW-1:0] op_b  = '0;
  logic          busy, done;
  logic [DW-1:0] result;

  int total = 0;
  int bad   = 0;

  mdu_iter #(.DATA_WIDTH(DW), .OP_WIDTH(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: RV32M semantics from plain 64-bit arithmetic.
  function automatic logic [31:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    int              ia, ib;
    logic            ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ia  = $signed(a);
    ib  = $signed(b);
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (o)
      3'd0: begin p = 64'(ua * ub); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
      3'd3: begin p = 64'(ua * ub); return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(ia / ib);
      end
      3'd5: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 32'd0) return a;
        if (ovf) return 32'd0;
        return 32'(ia % ib);
      end
      default: begin
        if (b == 32'd0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 32'd0)) return 2;
    if (o[2] && !o[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) return 2;
    return DW + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      5:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called in an idle cycle, #1 after an edge; returns in the idle cycle after done
  // (or after the abort), so the next call issues a back-to-back start.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int flush_at, input int poke_at, input string tag);
    logic [31:0] exp_res, prev;
    int          lat, done_cyc;
    logic        exp_busy;
    exp_res  = ref_result(o, a, b);
    lat      = ref_lat(o, a, b);
    prev     = result;
    done_cyc = 0;
    op = o; op_a = a; op_b = b; start = 1'b1; flush = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 45; k++) begin
      exp_busy = (k < lat) && (flush_at == 0 || k <= flush_at);
      check({tag, "_busy"}, 64'(busy), 64'(exp_busy));
      if (done) begin
        done_cyc = k;
        break;
      end
      // Scramble the request inputs to show the captured copies are used.
      op    = 3'($urandom);
      op_a  = $urandom;
      op_b  = $urandom;
      start = (k == poke_at);
      flush = (k == flush_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    flush = 1'b0;
    if (flush_at > 0) begin
      check({tag, "_nodone"}, 64'(done_cyc), 64'd0);
      check({tag, "_held"}, 64'(result), 64'(prev));
    end else begin
      check({tag, "_lat"}, 64'(done_cyc), 64'(lat));
      check({tag, "_res"}, 64'(result), 64'(exp_res));
      @(posedge clk); #1;
      check({tag, "_pulse"}, 64'(done), 64'd0);
      check({tag, "_hold"}, 64'(result), 64'(exp_res));
    end
  endtask

  initial begin
    // Reset values
    #3;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;

    // Directed vectors; the first start lands on the first edge after reset release
    run_op(3'd0, 32'd7,          32'hFFFF_FFFD, 0, 0, "mul");
    run_op(3'd1, 32'h8000_0000,  32'h8000_0000, 0, 0, "mulh");
    run_op(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, "mulhu");
    run_op(3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 0, 0, "mulhsu");
    run_op(3'd4, 32'hFFFF_FFF9,  32'd2,         0, 0, "div");
    run_op(3'd6, 32'hFFFF_FFF9,  32'd2,         0, 0, "rem");
    run_op(3'd5, 32'd100,        32'd7,         0, 0, "divu");
    run_op(3'd7, 32'd100,        32'd7,         0, 0, "remu");
    run_op(3'd5, 32'h0000_1234,  32'd0,         0, 0, "divu0");
    run_op(3'd6, 32'h0000_1234,  32'd0,         0, 0, "rem0");
    run_op(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, "div_ovf");
    run_op(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 0, 0, "rem_ovf");

    // Start while busy is ignored; then a flushed operation leaves result alone
    run_op(3'd0, 32'd1234,       32'd5678,      0, 5, "poke");
    run_op(3'd5, 32'd100,        32'd7,         0, 0, "pre_flush");
    run_op(3'd0, 32'hDEAD_BEEF,  32'd3,        10, 0, "flush");

    // Flush together with start in idle suppresses acceptance (fast-path op)
    op = 3'd5; op_a = 32'd9; op_b = 32'd0; start = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    check("idle_flush_done", 64'(done), 64'd0);
    check("idle_flush_res", 64'(result), 64'd14);

    // Reset in cycle 12 of a divide
    op = 3'd4; op_a = 32'h1357_9BDF; op_b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check("mid_busy", 64'(busy), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_result", 64'(result), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_hold_done", 64'(done), 64'd0);
    rst = 1'b1;
    run_op(3'd0, 32'd3, 32'd5, 0, 0, "post_rst");

    // Randomized operations
    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick(), 0, 0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
